vend_sequencer: RTL

- Front-end controller that sequences the vending_machine core.
- Queues coin events from the coin-acceptor interface and feeds them to the core's `in` port as single-cycle pulses.
- Watches the core's `out`/`change` result, then runs timed dispense-motor and change-ejector pulses.
- Sits between the panel/acceptor logic and the vending_machine core; both share `clk`/`rst`.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/coin_fifo.sv | 61 ++++++
 rtl/vend_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared coin/change codes, FSM state encodings and small helpers for the vend sequencer.
package vend_pkg;

    typedef logic [1:0] coin_t;
    typedef logic [2:0] state_t;

    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_5    = 2'b01;
    localparam coin_t COIN_10   = 2'b10;
    localparam coin_t COIN_BAD  = 2'b11;

    localparam state_t IDLE     = 3'd0;
    localparam state_t ISSUE    = 3'd1;
    localparam state_t SETTLE   = 3'd2;
    localparam state_t DISPENSE = 3'd3;
    localparam state_t EJECT    = 3'd4;

    function automatic logic coin_is_valid(input coin_t c);
        return (c == COIN_5) || (c == COIN_10);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small synchronous FIFO for 2-bit coin codes; extra pointer MSB separates full from empty.
module coin_fifo
    import vend_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  coin_t wdata,
    output coin_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    coin_t         mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Front-end for the vending_machine core: queues acceptor coins, issues them as single-cycle
// pulses, watches the core result and runs timed dispense-motor and change-ejector pulses.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned SETTLE_CYCLES   = 2,
    parameter int unsigned DISPENSE_CYCLES = 8,
    parameter int unsigned EJECT_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    output logic       coin_ready,
    output logic       bad_coin,
    output logic [1:0] vm_in,
    input  logic       vm_out,
    input  logic [1:0] vm_change,
    output logic       motor_en,
    output logic       eject_en,
    output logic [1:0] eject_coin,
    output logic       busy,
    output logic [7:0] vend_count
);

    localparam int unsigned CNT_MAX = max3(SETTLE_CYCLES, DISPENSE_CYCLES, EJECT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    coin_t            chg_q, chg_d;
    coin_t            vm_in_q, vm_in_d;
    logic             bad_q, bad_d;
    logic [7:0]       vend_cnt_q, vend_cnt_d;

    logic  fifo_full;
    logic  fifo_empty;
    coin_t fifo_head;
    logic  push;
    logic  pop;

    assign push = coin_valid & ~fifo_full & coin_is_valid(coin_val);
    assign pop  = (state_q == IDLE) & ~fifo_empty;

    coin_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_coin_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(coin_val),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chg_d      = chg_q;
        vend_cnt_d = vend_cnt_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = SETTLE;
                cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
                // Change is only meaningful alongside a vend; otherwise the core is still crediting.
                if (vm_out) begin
                    chg_d      = vm_change;
                    vend_cnt_d = vend_cnt_q + 8'd1;
                    state_d    = DISPENSE;
                    cnt_d      = CNT_W'(DISPENSE_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DISPENSE: begin
                if (cnt_q == '0) begin
                    if (chg_q != COIN_NONE) begin
                        state_d = EJECT;
                        cnt_d   = CNT_W'(EJECT_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            EJECT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    chg_d   = COIN_NONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                chg_d   = COIN_NONE;
            end
        endcase
    end

    assign vm_in_d = pop ? fifo_head : COIN_NONE;
    assign bad_d   = coin_valid & ~coin_is_valid(coin_val);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            chg_q      <= COIN_NONE;
            vm_in_q    <= COIN_NONE;
            bad_q      <= 1'b0;
            vend_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chg_q      <= chg_d;
            vm_in_q    <= vm_in_d;
            bad_q      <= bad_d;
            vend_cnt_q <= vend_cnt_d;
        end
    end

    // Actuators are gated by rst so an abort drops them in the reset cycle itself.
    assign motor_en   = rst & (state_q == DISPENSE);
    assign eject_en   = rst & (state_q == EJECT);
    assign eject_coin = eject_en ? chg_q : COIN_NONE;

    assign coin_ready = ~fifo_full;
    assign bad_coin   = bad_q;
    assign vm_in      = vm_in_q;
    assign busy       = (state_q != IDLE) | ~fifo_empty;
    assign vend_count = vend_cnt_q;

endmodule
